uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first) fed from a small byte FIFO; bytes are sent back-to-back.
// Latency: a byte written into an empty FIFO while idle drives the start bit after the second following edge.
// Backpressure: o_Tx_Ready drops while the FIFO holds FIFO_DEPTH bytes; writes then are ignored.

module uart_tx_byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [WIDTH-1:0]         in_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [WIDTH-1:0]         out_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Ready and valid come from the pre-edge count, so a push while full is dropped
    // even when the head is popped on the same edge.
    assign in_rdy  = (count < FULL);
    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    // Storage array, written at the tail; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    // Pointers wrap naturally; count tracks occupancy including simultaneous push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 435,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] CLEANUP = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          head_vld;
    logic [7:0]    head_dat;
    logic          pop;
    logic          bit_end;
    logic          line_nxt;
    logic          active_nxt;

    // The FSM only takes a byte when it is sitting idle with something queued.
    assign pop     = (state == IDLE) && head_vld;
    assign bit_end = (clk_cnt == LAST_CLK);

    uart_tx_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .in_vld  (i_Tx_DV),
        .in_rdy  (o_Tx_Ready),
        .in_dat  (i_Tx_Byte),
        .out_vld (head_vld),
        .out_rdy (pop),
        .out_dat (head_dat),
        .count   (o_Fifo_Count)
    );

    // Frame sequencer: start, eight data bits, stop, one cleanup cycle, back to idle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (head_vld) begin
                        shift   <= head_dat;
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        state   <= CLEANUP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                CLEANUP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line level and busy flag decoded from the current state and bit index.
    always_comb begin
        line_nxt   = 1'b1;
        active_nxt = 1'b0;
        case (state)
            START: begin
                line_nxt   = 1'b0;
                active_nxt = 1'b1;
            end
            DATA: begin
                line_nxt   = shift[bit_idx];
                active_nxt = 1'b1;
            end
            STOP: begin
                line_nxt   = 1'b1;
                active_nxt = 1'b1;
            end
            default: begin
                line_nxt   = 1'b1;
                active_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs lag the state by one cycle, so Done lands exactly as the stop bit ends.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Serial <= line_nxt;
            o_Tx_Active <= active_nxt;
            o_Tx_Done   <= (state == CLEANUP);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int CPB      = 4;
    localparam int DEPTH    = 4;
    localparam int SLOW_CPB = 435;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Fast instance
    logic       rst, dv;
    logic [7:0] din;
    logic       ready, serial, active, done;
    logic [2:0] fcount;

    // Loopback instance at the receiver's bit rate
    logic       s_rst, s_dv;
    logic [7:0] s_din;
    logic       s_ready, s_serial, s_active, s_done;
    logic [2:0] s_count;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv), .i_Tx_Byte(din),
        .o_Tx_Ready(ready), .o_Tx_Serial(serial), .o_Tx_Active(active),
        .o_Tx_Done(done), .o_Fifo_Count(fcount)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(SLOW_CPB), .FIFO_DEPTH(DEPTH)) u_dut_slow (
        .i_Clock(clk), .i_Reset(s_rst), .i_Tx_DV(s_dv), .i_Tx_Byte(s_din),
        .o_Tx_Ready(s_ready), .o_Tx_Serial(s_serial), .o_Tx_Active(s_active),
        .o_Tx_Done(s_done), .o_Fifo_Count(s_count)
    );

    int tests = 0;
    int fails = 0;
    int t = 0;

    // Reference model: queued bytes, the frame in flight and when the next pop may happen.
    logic [7:0] q[$];
    int         next_pop = 0;
    int         cur_p = -1;
    logic [7:0] cur_byte = 8'h00;
    int         done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    // Apply one clock edge to the model. A frame popped at edge P occupies the line after
    // edges P+1 .. P+10*CPB, Done follows after edge P+1+10*CPB, next pop at P+10*CPB+2.
    task automatic model_edge(input logic r, input logic v, input logic [7:0] b);
        int pre;
        if (r) begin
            q.delete();
            cur_p    = -1;
            next_pop = t + 1;
        end else begin
            pre = q.size();
            if (pre > 0 && t >= next_pop) begin
                cur_byte = q.pop_front();
                cur_p    = t;
                next_pop = t + 10*CPB + 2;
            end
            if (v && pre < DEPTH) q.push_back(b);
        end
    endtask

    task automatic check_outputs();
        int   k;
        logic es, ea, ed;
        es = 1'b1; ea = 1'b0; ed = 1'b0;
        if (cur_p >= 0) begin
            if (t >= cur_p + 1 && t < cur_p + 1 + 10*CPB) begin
                k  = (t - cur_p - 1) / CPB;
                ea = 1'b1;
                if (k == 0)     es = 1'b0;
                else if (k < 9) es = cur_byte[k-1];
            end
            ed = (t == cur_p + 1 + 10*CPB);
        end
        check("serial", 32'(serial), 32'(es));
        check("active", 32'(active), 32'(ea));
        check("done",   32'(done),   32'(ed));
        check("count",  32'(fcount), 32'(q.size()));
        check("ready",  32'(ready),  32'(q.size() < DEPTH));
        if (done === 1'b1) done_seen++;
    endtask

    // Called at a negedge (or time 0): drive inputs, advance model, clock, then compare.
    task automatic cycle(input logic r, input logic v, input logic [7:0] b);
        rst = r; dv = v; din = b;
        t++;
        model_edge(r, v, b);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         tw, tfall, tdone, guard;
        logic [7:0] rx;
        logic [7:0] lb_bytes [4];

        rst = 1'b1; dv = 1'b0; din = 8'h00;
        s_rst = 1'b1; s_dv = 1'b0; s_din = 8'h00;

        // Reset state
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);
        check("rst_serial", 32'(serial), 32'd1);
        check("rst_count",  32'(fcount), 32'd0);
        check("rst_ready",  32'(ready),  32'd1);

        // Single byte 0x55: start-bit latency and Done position
        cycle(1'b0, 1'b1, 8'h55);
        tw = t; tfall = -1; tdone = -1;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            if (serial === 1'b0 && tfall < 0) tfall = t;
            if (done === 1'b1 && tdone < 0) tdone = t;
        end
        check("fall_latency", 32'(tfall - tw), 32'd2);
        check("done_offset",  32'(tdone - tfall), 32'd40);

        // Six-cycle burst into a depth-4 FIFO: 0x06 is dropped, five frames go out
        done_seen = 0;
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b0, 1'b1, 8'(i));
            if (i >= 5) begin
                check("burst_full_count", 32'(fcount), 32'd4);
                check("burst_full_ready", 32'(ready),  32'd0);
            end
        end
        for (int i = 0; i < 240; i++) cycle(1'b0, 1'b0, 8'h00);
        check("burst_done_pulses", 32'(done_seen), 32'd5);
        check("burst_final_count", 32'(fcount), 32'd0);

        // Push while full on the same edge the FSM pops
        cycle(1'b0, 1'b1, 8'hA0);
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 8'hA0 + 8'(i));
        check("full_before", 32'(fcount), 32'd4);
        guard = 0;
        while (t + 1 < next_pop && guard < 100) begin
            cycle(1'b0, 1'b0, 8'h00);
            guard++;
        end
        cycle(1'b0, 1'b1, 8'hEE);
        check("full_pop_count", 32'(fcount), 32'd3);
        for (int i = 0; i < 200; i++) cycle(1'b0, 1'b0, 8'h00);

        // Reset during data bit 3 of 0xF0 with two bytes queued
        cycle(1'b0, 1'b1, 8'hF0);
        cycle(1'b0, 1'b1, 8'h11);
        cycle(1'b0, 1'b1, 8'h22);
        check("mid_queued", 32'(fcount), 32'd2);
        guard = 0;
        while (t < cur_p + 1 + 4*CPB && guard < 100) begin
            cycle(1'b0, 1'b0, 8'h00);
            guard++;
        end
        check("mid_bit3", 32'(serial), 32'd0);
        done_seen = 0;
        cycle(1'b1, 1'b0, 8'h00);
        check("mid_rst_serial", 32'(serial), 32'd1);
        check("mid_rst_count",  32'(fcount), 32'd0);
        check("mid_rst_active", 32'(active), 32'd0);
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b0, 8'h00);
        check("mid_rst_no_done", 32'(done_seen), 32'd0);

        // Long idle
        done_seen = 0;
        for (int i = 0; i < 1000; i++) cycle(1'b0, 1'b0, 8'h00);
        check("idle_no_done", 32'(done_seen), 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0),
                  8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 8'h00);
        check("random_drained", 32'(fcount), 32'd0);

        // Loopback at the receiver's bit rate through a behavioural mid-bit sampler
        rst = 1'b0; dv = 1'b0;
        lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'hA5; lb_bytes[3] = 8'h3C;
        @(posedge clk); @(negedge clk);
        s_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_dv = 1'b1; s_din = lb_bytes[i];
            @(posedge clk); @(negedge clk);
        end
        s_dv = 1'b0;
        for (int f = 0; f < 4; f++) begin
            guard = 0;
            while (s_serial !== 1'b0 && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            check("lb_start_found", 32'(s_serial), 32'd0);
            repeat (SLOW_CPB/2) @(negedge clk);
            check("lb_start_bit", 32'(s_serial), 32'd0);
            rx = 8'h00;
            for (int b = 0; b < 8; b++) begin
                repeat (SLOW_CPB) @(negedge clk);
                rx[b] = s_serial;
            end
            repeat (SLOW_CPB) @(negedge clk);
            check("lb_stop_bit", 32'(s_serial), 32'd1);
            check("lb_byte", 32'(rx), 32'(lb_bytes[f]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
